sync_fifo_param: RTL

// - Parametrised single-clock FIFO; next generation of the parser->copy buffer in the Snappy decompressor.
// - Generic width/depth, programmable full/empty thresholds, occupancy count and overflow/underflow flags.
// - Two read modes: standard (registered dout, 1-cycle latency) or first-word-fall-through (FWFT).
// - Drop-in for the parser->copy and copy->selector channels; one instance per token stream.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ptr_ctrl.sv | 74 +++++++
 rtl/sync_fifo_param.sv | 97 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: address width helper, parameter checks, read modes.
// Latency: none (package only).
// Backpressure: not applicable.
package fifo_pkg;

  // Read-mode selector values for the FWFT parameter
  localparam bit FIFO_STD  = 1'b0;
  localparam bit FIFO_FWFT = 1'b1;

  // Pointer width for a given depth
  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

  // Depth must be a power of two and at least 2 so pointers wrap for free
  function automatic bit fifo_is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/occupancy controller: read/write pointers, count, status flags, error pulses and reset-busy.
// Latency: flags decode from the registered count, so they reflect a request one cycle later.
// Backpressure: writes refused while full, reads refused while empty, both refused while reset-busy.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter  int DEPTH      = 8,
  parameter  int PROG_FULL  = 3,
  parameter  int PROG_EMPTY = 1,
  localparam int AW         = fifo_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic          wr_acc,
  output logic          rd_acc,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          prog_full,
  output logic          prog_empty,
  output logic          overflow,
  output logic          underflow,
  output logic          rst_busy
);

  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_PFULL = (AW+1)'(PROG_FULL);
  localparam logic [AW:0]   CNT_PEMPT = (AW+1)'(PROG_EMPTY);
  localparam logic [AW:0]   CNT_STEP  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_STEP  = AW'(1);

  logic rst_busy_q;

  // Busy covers the reset cycle itself and the first cycle after reset releases
  assign rst_busy = srst | rst_busy_q;

  // Status is decoded from the registered count only; no path from the request inputs
  assign full       = (count == CNT_FULL);
  assign empty      = (count == '0);
  assign prog_full  = (count >= CNT_PFULL);
  assign prog_empty = (count <= CNT_PEMPT);

  // Full blocks a write even when a read retires a word in the same cycle
  assign wr_acc = wr_en & ~full  & ~rst_busy;
  assign rd_acc = rd_en & ~empty & ~rst_busy;

  // Pointer, occupancy and error-pulse state
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      rst_busy_q <= 1'b1;
    end else begin
      rst_busy_q <= 1'b0;
      if (wr_acc) wr_ptr <= wr_ptr + PTR_STEP;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_STEP;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_STEP;
        2'b01:   count <= count - CNT_STEP;
        default: count <= count;
      endcase
      overflow  <= wr_en & full  & ~rst_busy_q;
      underflow <= rd_en & empty & ~rst_busy_q;
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable thresholds and standard or first-word-fall-through read.
// Latency: standard mode presents a word one cycle after an accepted read; FWFT presents the head one cycle after its write.
// Backpressure: full/prog_full toward the writer, empty/valid toward the reader; rejected requests pulse overflow/underflow.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int WIDTH      = 33,
  parameter  int DEPTH      = 8,
  parameter  int PROG_FULL  = 3,
  parameter  int PROG_EMPTY = 1,
  parameter  bit FWFT       = FIFO_STD,
  localparam int AW         = fifo_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic             prog_full,
  output logic             overflow,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             empty,
  output logic             prog_empty,
  output logic             underflow,
  output logic [AW:0]      data_count,
  output logic             wr_rst_busy,
  output logic             rd_rst_busy
);

  if (!fifo_is_pow2(DEPTH)) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if (PROG_FULL < 1 || PROG_FULL > DEPTH) begin : g_bad_pfull
    $fatal(1, "sync_fifo_param: PROG_FULL must lie in 1..DEPTH");
  end
  if (PROG_EMPTY < 0 || PROG_EMPTY > DEPTH - 1) begin : g_bad_pempty
    $fatal(1, "sync_fifo_param: PROG_EMPTY must lie in 0..DEPTH-1");
  end

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic             rst_busy;
  logic [WIDTH-1:0] mem [DEPTH];

  fifo_ptr_ctrl #(
    .DEPTH      (DEPTH),
    .PROG_FULL  (PROG_FULL),
    .PROG_EMPTY (PROG_EMPTY)
  ) u_ctrl (
    .clk        (clk),
    .srst       (srst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .wr_acc     (wr_acc),
    .rd_acc     (rd_acc),
    .count      (data_count),
    .full       (full),
    .empty      (empty),
    .prog_full  (prog_full),
    .prog_empty (prog_empty),
    .overflow   (overflow),
    .underflow  (underflow),
    .rst_busy   (rst_busy)
  );

  assign wr_rst_busy = rst_busy;
  assign rd_rst_busy = rst_busy;

  // Storage array, no reset so it maps onto distributed RAM
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // Head word is visible combinationally; forced to zero while empty so stale data never leaks
    assign dout  = empty ? '0 : mem[rd_ptr];
    assign valid = ~empty;
  end else begin : g_std
    // Registered read port: valid pulses for one cycle per accepted read, dout holds otherwise
    always_ff @(posedge clk) begin
      if (srst) begin
        dout  <= '0;
        valid <= 1'b0;
      end else begin
        valid <= rd_acc;
        if (rd_acc) dout <= mem[rd_ptr];
      end
    end
  end

endmodule
